lifo_stack: RTL and testbench
=============================

# lifo_stack

Parametrised LIFO stack: the successor to the minimal circular stack, used as the return-address/operand stack in the team's small CPU and sequencer cores. Adds selectable depth and width, full/empty/count status, a zero-latency registered top-of-stack output, a push-pop replace operation, a synchronous flush, and a compile-time choice between bounded (reject on full) and circular (overwrite oldest) behaviour, with overflow/underflow event pulses.

## Interface
- `WIDTH`, 18, bit width of each stack word.
- `DEPTH_LOG2`, 4, capacity is `DEPTH = 2**DEPTH_LOG2` words; legal range 1..10.
- `CIRCULAR`, 0, 0 = bounded (push on full rejected); 1 = circular (push on full overwrites oldest entry).

- `i_clk`, in, 1, single clock; all state changes on rising edge.
- `i_rst`, in, 1, reset, synchronous, active-high.
- `i_flush`, in, 1, synchronous empty of the stack.
- `i_push`, in, 1, push `i_data` this cycle.
- `i_pop`, in, 1, pop top this cycle.
- `i_data`, in, `WIDTH`, write data.
- `o_data`, out, `WIDTH`, registered current top of stack; 0 when empty.
- `o_count`, out, `DEPTH_LOG2+1`, number of valid entries, 0..DEPTH.
- `o_empty`, out, 1, `o_count == 0`.
- `o_full`, out, 1, `o_count == DEPTH`.
- `o_overflow`, out, 1, one-cycle pulse: push found stack full.
- `o_underflow`, out, 1, one-cycle pulse: pop found stack empty.

## Operation
- State: storage `mem[0..DEPTH-1]`, write pointer `wp` (`DEPTH_LOG2` bits, wraps modulo DEPTH), `count`, `o_data` register. Top lives at `mem[wp-1]`.
- Priority per cycle: `i_rst` > `i_flush` > push/pop decode.
- Reset and flush: `wp=0`, `count=0`, `o_data=0`, `o_empty=1`, `o_full=0`, both pulses 0. Memory contents not cleared.
- Push only, not full: `mem[wp]<=i_data`, `wp+1`, `count+1`, `o_data<=i_data`.
- Push only, full, `CIRCULAR=0`: no state change, `o_overflow=1`.
- Push only, full, `CIRCULAR=1`: `mem[wp]` (the oldest entry) overwritten, `wp+1`, `count` stays DEPTH, `o_data<=i_data`, `o_overflow=1`.
- Pop only, `count>=2`: `wp-1`, `count-1`, `o_data<=mem[wp-2]`.
- Pop only, `count==1`: `wp-1`, `count=0`, `o_data<=0`.
- Pop only, empty: no state change, `o_underflow=1`.
- Push and pop (replace), not empty: `mem[wp-1]<=i_data`, `o_data<=i_data`, `wp`/`count` unchanged, no pulse (also when full).
- Push and pop, empty: treated as push only (`count=1`, `o_data=i_data`), `o_underflow=1`.
- Pointer arithmetic truncated to `DEPTH_LOG2` bits; wrap 0↔DEPTH-1 is normal in both modes. In circular mode, after wrap, pops return newest-first down to the oldest surviving entry; pop beyond that yields underflow.

## Timing
- All outputs registered; results of an operation at edge N visible after edge N.
- `o_data` reflects the new top in the cycle after push, pop, or replace: zero extra latency, no read request.
- `o_overflow`/`o_underflow` high for exactly the one cycle after the offending edge; deasserted by reset/flush.
- Back-to-back operations every cycle supported; no stall or ready.
- Storage read is asynchronous (distributed RAM / registers); write is synchronous.

## Structure
- Header `stack_defs.vh`: op-decode localparams `OP_NONE`, `OP_PUSH`, `OP_POP`, `OP_REPL` derived from `{i_push,i_pop}`.
- One sub-module: `stack_mem` (1 write port, 2 async read ports at `wp-1`/`wp-2`, parametrised by `WIDTH`/`DEPTH_LOG2`).
- Top holds pointer, count, flags, and `o_data` register.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 -> `o_data` 0x11,0x22,0x33 per cycle, `o_count`=3; pop ×3 -> `o_data` 0x22,0x11,0, `o_empty`=1.
- `DEPTH_LOG2=2`, `CIRCULAR=0`: push 1..5 -> `o_full` after 4th, 5th push gives `o_overflow` pulse, `o_data` stays 4; pop ×4 -> 3,2,1,0.
- `DEPTH_LOG2=2`, `CIRCULAR=1`: push 1..6 -> `o_overflow` on 5th and 6th, `o_count`=4; pop ×5 -> 5,4,3,0 then `o_underflow` on 5th pop.
- Replace: push 0xA, 0xB, then push+pop 0xC -> `o_data`=0xC, `o_count`=2; pop -> 0xA.
- Empty: pop -> `o_underflow` pulse, count 0; push+pop 0x5 on empty -> `o_count`=1, `o_data`=0x5, `o_underflow` pulse.
- Flush/reset mid-stream: push 3 words, assert `i_flush` with `i_push` -> `o_count`=0, `o_data`=0; repeat with `i_rst` -> same, pulses cleared.

Source files
------------

// File: rtl/lifo_stack_pkg.sv
// Shared types for the LIFO stack: operation decode from the push/pop pair.
package lifo_stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  function automatic op_e op_decode(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Stack command/status bundle. master drives commands, slave is the stack.
interface lifo_stack_if #(
  parameter int WIDTH      = 18,
  parameter int DEPTH_LOG2 = 4
);
  logic                  i_flush;
  logic                  i_push;
  logic                  i_pop;
  logic [WIDTH-1:0]      i_data;
  logic [WIDTH-1:0]      o_data;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_empty;
  logic                  o_full;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_flush, i_push, i_pop, i_data,
    input  o_data, o_count, o_empty, o_full, o_overflow, o_underflow
  );

  modport slave (
    input  i_flush, i_push, i_pop, i_data,
    output o_data, o_count, o_empty, o_full, o_overflow, o_underflow
  );
endinterface

// File: rtl/lifo_stack_mem.sv
// Stack storage: one synchronous write port, two asynchronous read ports
// (current top and the entry beneath it) so a pop can load the new top
// into the output register in the same cycle.
module stack_mem #(
  parameter int WIDTH      = 18,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr_top,
  input  logic [DEPTH_LOG2-1:0] raddr_next,
  output logic [WIDTH-1:0]      rdata_top,
  output logic [WIDTH-1:0]      rdata_next
);
  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Write port; contents are intentionally never cleared.
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_top  = mem[raddr_top];
  assign rdata_next = mem[raddr_next];
endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with registered top-of-stack, replace, flush and
// a compile-time bounded/circular full policy.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int DEPTH_LOG2 = 4,
  parameter bit CIRCULAR   = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  lifo_stack_if.slave bus
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(1 << DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wp, wp_n, waddr, ra_top, ra_next;
  logic [CW-1:0]         cnt, cnt_n;
  logic [WIDTH-1:0]      top, top_n, rd_top, rd_next;
  logic                  ovf, ovf_n, unf, unf_n, empty, full, we;
  op_e                   op;

  assign op      = op_decode(bus.i_push, bus.i_pop);
  assign ra_top  = wp - DEPTH_LOG2'(1);
  assign ra_next = wp - DEPTH_LOG2'(2);

  stack_mem #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .i_clk      (i_clk),
    .we         (we),
    .waddr      (waddr),
    .wdata      (bus.i_data),
    .raddr_top  (ra_top),
    .raddr_next (ra_next),
    .rdata_top  (rd_top),
    .rdata_next (rd_next)
  );

  // Next-state decode: reset > flush > push/pop operation.
  always_comb begin
    wp_n  = wp;
    cnt_n = cnt;
    top_n = top;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    we    = 1'b0;
    waddr = wp;
    if (i_rst || bus.i_flush) begin
      wp_n  = '0;
      cnt_n = '0;
      top_n = '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          if (full) ovf_n = 1'b1;
          if (!full || CIRCULAR) begin
            // In circular mode wp already points at the oldest entry when full.
            we    = 1'b1;
            wp_n  = wp + DEPTH_LOG2'(1);
            cnt_n = full ? cnt : cnt + CW'(1);
            top_n = bus.i_data;
          end
        end
        OP_POP: begin
          if (empty) begin
            unf_n = 1'b1;
          end else begin
            wp_n  = ra_top;
            cnt_n = cnt - CW'(1);
            top_n = (cnt == CW'(1)) ? '0 : rd_next;
          end
        end
        OP_REPL: begin
          we    = 1'b1;
          top_n = bus.i_data;
          if (empty) begin
            // Nothing to replace: behaves as a push, flagged as underflow.
            unf_n = 1'b1;
            wp_n  = wp + DEPTH_LOG2'(1);
            cnt_n = CW'(1);
          end else begin
            waddr = ra_top;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; status flags are registered from the next count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp    <= '0;
      cnt   <= '0;
      top   <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wp    <= wp_n;
      cnt   <= cnt_n;
      top   <= top_n;
      ovf   <= ovf_n;
      unf   <= unf_n;
      empty <= (cnt_n == '0);
      full  <= (cnt_n == FULL_CNT);
    end
  end

  // rd_top is unused on purpose: the registered copy serves the output.
  logic unused_rd_top;
  assign unused_rd_top = ^rd_top;

  assign bus.o_data      = top;
  assign bus.o_count     = cnt;
  assign bus.o_empty     = empty;
  assign bus.o_full      = full;
  assign bus.o_overflow  = ovf;
  assign bus.o_underflow = unf;
endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack: three instances (16-deep bounded, 4-deep
// bounded, 4-deep circular) share stimulus; each vector checks one of them.
module tb_lifo_stack;
  logic clk = 1'b0;
  logic rst, flush, push, pop;
  logic [17:0] din;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lifo_stack_if #(.WIDTH(18), .DEPTH_LOG2(4)) b0 ();
  lifo_stack_if #(.WIDTH(18), .DEPTH_LOG2(2)) b1 ();
  lifo_stack_if #(.WIDTH(18), .DEPTH_LOG2(2)) b2 ();

  assign b0.i_flush = flush; assign b0.i_push = push; assign b0.i_pop = pop; assign b0.i_data = din;
  assign b1.i_flush = flush; assign b1.i_push = push; assign b1.i_pop = pop; assign b1.i_data = din;
  assign b2.i_flush = flush; assign b2.i_push = push; assign b2.i_pop = pop; assign b2.i_data = din;

  lifo_stack #(.WIDTH(18), .DEPTH_LOG2(4), .CIRCULAR(1'b0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(b0));
  lifo_stack #(.WIDTH(18), .DEPTH_LOG2(2), .CIRCULAR(1'b0)) dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));
  lifo_stack #(.WIDTH(18), .DEPTH_LOG2(2), .CIRCULAR(1'b1)) dut2 (.i_clk(clk), .i_rst(rst), .bus(b2));

  typedef struct {
    logic        rst, flush, push, pop;
    logic [17:0] din;
    int          sel;
    logic [17:0] ed;
    int          ec;
    logic        ee, ef, eo, eu;
  } vec_t;

  vec_t tv[$];

  task automatic add(input int sel, input logic r, input logic f, input logic pu, input logic po,
                     input logic [17:0] d, input logic [17:0] ed, input int ec,
                     input logic ee, input logic ef, input logic eo, input logic eu);
    vec_t v;
    v.sel = sel; v.rst = r; v.flush = f; v.push = pu; v.pop = po; v.din = d;
    v.ed = ed; v.ec = ec; v.ee = ee; v.ef = ef; v.eo = eo; v.eu = eu;
    tv.push_back(v);
  endtask

  task automatic step(input logic r, input logic f, input logic pu, input logic po, input logic [17:0] d);
    @(negedge clk);
    rst = r; flush = f; push = pu; pop = po; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int sel, input logic [17:0] ed, input int ec,
                     input logic ee, input logic ef, input logic eo, input logic eu);
    logic [17:0] ad;
    int          ac;
    logic        ae, af, ao, au;
    case (sel)
      0: begin ad = b0.o_data; ac = int'(b0.o_count); ae = b0.o_empty; af = b0.o_full; ao = b0.o_overflow; au = b0.o_underflow; end
      1: begin ad = b1.o_data; ac = int'(b1.o_count); ae = b1.o_empty; af = b1.o_full; ao = b1.o_overflow; au = b1.o_underflow; end
      default: begin ad = b2.o_data; ac = int'(b2.o_count); ae = b2.o_empty; af = b2.o_full; ao = b2.o_overflow; au = b2.o_underflow; end
    endcase
    total++;
    if (ad !== ed || ac != ec || ae !== ee || af !== ef || ao !== eo || au !== eu) begin
      bad++;
      $display("FAIL %s dut%0d: got data=%h cnt=%0d e=%b f=%b ovf=%b unf=%b want data=%h cnt=%0d e=%b f=%b ovf=%b unf=%b",
               name, sel, ad, ac, ae, af, ao, au, ed, ec, ee, ef, eo, eu);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0;

    // basic push/pop, 16-deep
    add(0,1,0,0,0,0,  0,0,1,0,0,0);
    add(0,0,0,1,0,'h11,'h11,1,0,0,0,0);
    add(0,0,0,1,0,'h22,'h22,2,0,0,0,0);
    add(0,0,0,1,0,'h33,'h33,3,0,0,0,0);
    add(0,0,0,0,1,0,  'h22,2,0,0,0,0);
    add(0,0,0,0,1,0,  'h11,1,0,0,0,0);
    add(0,0,0,0,1,0,  0,0,1,0,0,0);
    // bounded 4-deep overflow
    add(1,1,0,0,0,0,  0,0,1,0,0,0);
    add(1,0,0,1,0,1,  1,1,0,0,0,0);
    add(1,0,0,1,0,2,  2,2,0,0,0,0);
    add(1,0,0,1,0,3,  3,3,0,0,0,0);
    add(1,0,0,1,0,4,  4,4,0,1,0,0);
    add(1,0,0,1,0,5,  4,4,0,1,1,0);
    add(1,0,0,0,1,0,  3,3,0,0,0,0);
    add(1,0,0,0,1,0,  2,2,0,0,0,0);
    add(1,0,0,0,1,0,  1,1,0,0,0,0);
    add(1,0,0,0,1,0,  0,0,1,0,0,0);
    // circular 4-deep wrap and underflow
    add(2,1,0,0,0,0,  0,0,1,0,0,0);
    add(2,0,0,1,0,1,  1,1,0,0,0,0);
    add(2,0,0,1,0,2,  2,2,0,0,0,0);
    add(2,0,0,1,0,3,  3,3,0,0,0,0);
    add(2,0,0,1,0,4,  4,4,0,1,0,0);
    add(2,0,0,1,0,5,  5,4,0,1,1,0);
    add(2,0,0,1,0,6,  6,4,0,1,1,0);
    add(2,0,0,0,1,0,  5,3,0,0,0,0);
    add(2,0,0,0,1,0,  4,2,0,0,0,0);
    add(2,0,0,0,1,0,  3,1,0,0,0,0);
    add(2,0,0,0,1,0,  0,0,1,0,0,0);
    add(2,0,0,0,1,0,  0,0,1,0,0,1);
    // replace
    add(0,1,0,0,0,0,  0,0,1,0,0,0);
    add(0,0,0,1,0,'hA,'hA,1,0,0,0,0);
    add(0,0,0,1,0,'hB,'hB,2,0,0,0,0);
    add(0,0,0,1,1,'hC,'hC,2,0,0,0,0);
    add(0,0,0,0,1,0,  'hA,1,0,0,0,0);
    // replace on full, bounded: no pulse
    add(1,1,0,0,0,0,  0,0,1,0,0,0);
    add(1,0,0,1,0,1,  1,1,0,0,0,0);
    add(1,0,0,1,0,2,  2,2,0,0,0,0);
    add(1,0,0,1,0,3,  3,3,0,0,0,0);
    add(1,0,0,1,0,4,  4,4,0,1,0,0);
    add(1,0,0,1,1,9,  9,4,0,1,0,0);
    add(1,0,0,0,1,0,  3,3,0,0,0,0);
    // empty corner cases
    add(0,1,0,0,0,0,  0,0,1,0,0,0);
    add(0,0,0,0,1,0,  0,0,1,0,0,1);
    add(0,0,0,1,1,5,  5,1,0,0,0,1);
    add(0,0,0,0,0,0,  5,1,0,0,0,0);
    add(0,0,0,0,1,0,  0,0,1,0,0,0);

    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].flush, tv[i].push, tv[i].pop, tv[i].din);
      chk($sformatf("vec%0d", i), tv[i].sel, tv[i].ed, tv[i].ec, tv[i].ee, tv[i].ef, tv[i].eo, tv[i].eu);
    end

    // flush wins over a concurrent push
    step(1,0,0,0,0);
    step(0,0,1,0,'h1);
    step(0,0,1,0,'h2);
    step(0,0,1,0,'h3);
    chk("pre_flush", 0, 'h3, 3, 0, 0, 0, 0);
    step(0,1,1,0,'h4);
    chk("flush_push", 0, 0, 0, 1, 0, 0, 0);

    // flush clears a pending overflow pulse
    step(0,0,1,0,'h1);
    step(0,0,1,0,'h2);
    step(0,0,1,0,'h3);
    step(0,0,1,0,'h4);
    step(0,0,1,0,'h5);
    chk("ovf_before_flush", 1, 'h4, 4, 0, 1, 1, 0);
    step(0,1,0,0,0);
    chk("flush_clears_ovf", 1, 0, 0, 1, 0, 0, 0);

    // reset mid-stream with push, and clears underflow pulse
    step(0,0,1,0,'h7);
    step(0,0,1,0,'h8);
    step(0,0,0,1,0);
    step(0,0,0,1,0);
    step(0,0,0,1,0);
    chk("unf_before_rst", 2, 0, 0, 1, 0, 0, 1);
    step(0,0,1,0,'h9);
    step(0,0,1,0,'hA);
    step(1,0,1,0,'hB);
    chk("rst_push", 2, 0, 0, 1, 0, 0, 0);
    step(0,0,1,0,'hC);
    chk("after_rst", 2, 'hC, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
